// File: rtl/seq_detector_param.sv
// seq_detector_param: serial pattern detector with a runtime-loaded pattern,
// a runtime length (1..PAT_W), overlapping or non-overlapping detection, and
// a saturating match counter. Every output comes straight from a flop.
module seq_detector_param #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8,
  parameter int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic             en,
  input  logic             w,
  output logic             z,
  output logic [CNT_W-1:0] match_count,
  output logic [LEN_W-1:0] busy_fill
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);

  // Registered configuration and detection state.
  logic [PAT_W-1:0] pat_r,     pat_n;
  logic [LEN_W-1:0] len_r,     len_n;
  logic             overlap_r, overlap_n;
  logic [PAT_W-1:0] hist_r,    hist_n;
  logic [LEN_W-1:0] fill_r,    fill_n;
  logic [CNT_W-1:0] cnt_r,     cnt_n;
  logic             z_r,       z_n;

  // Datapath helpers for the enabled-sample case.
  logic [PAT_W-1:0] shift_hist;
  logic [LEN_W-1:0] shift_fill;
  logic [PAT_W-1:0] len_mask;
  logic             match;

  // Next-state logic: load takes priority over a sample; reset is applied in the register.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
    pat_n      = pat_r;
    len_n      = len_r;
    overlap_n  = overlap_r;
    hist_n     = hist_r;
    fill_n     = fill_r;
    cnt_n      = cnt_r;
    z_n        = 1'b0;
    len_mask   = '0;

    shift_hist = {hist_r[PAT_W-2:0], w};
    shift_fill = (fill_r >= len_r) ? len_r : fill_r + LEN_W'(1);

    // Only the low len_r history bits take part in the compare.
    for (int i = 0; i < PAT_W; i++) begin
      len_mask[i] = (i < int'(len_r));
    end
    match = (shift_fill == len_r) && (((shift_hist ^ pat_r) & len_mask) == '0);

    if (load) begin
      pat_n     = cfg_pattern;
      overlap_n = cfg_overlap;
      len_n     = (cfg_len == '0 || cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
      hist_n    = '0;
      fill_n    = '0;
      cnt_n     = '0;
    end else if (en) begin
      hist_n = shift_hist;
      z_n    = match;
      if (match) begin
        cnt_n  = (cnt_r == '1) ? cnt_r : cnt_r + CNT_W'(1);
        // Non-overlap mode demands a fresh len_r bits before the next match.
        fill_n = overlap_r ? shift_fill : '0;
      end else begin
        fill_n = shift_fill;
      end
    end
  end

  // State register with synchronous active-low reset to the documented defaults.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values regardless of statement order.
      pat_r     <= '0;
      len_r     <= LEN_MAX;
      overlap_r <= 1'b1;
      hist_r    <= '0;
      fill_r    <= '0;
      cnt_r     <= '0;
      z_r       <= 1'b0;
    end else begin
      pat_r     <= pat_n;
      len_r     <= len_n;
      overlap_r <= overlap_n;
      hist_r    <= hist_n;
      fill_r    <= fill_n;
      cnt_r     <= cnt_n;
      z_r       <= z_n;
    end
  end

  assign z           = z_r;
  assign match_count = cnt_r;
  assign busy_fill   = fill_r;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed self-checking bench for seq_detector_param. A second instance with
// a 2-bit counter shares all inputs and is used for the saturation check.
module tb_seq_detector_param;

  localparam int PAT_W = 8;
  localparam int LEN_W = $clog2(PAT_W + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             load;
  logic [PAT_W-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic             cfg_overlap;
  logic             en;
  logic             w;
  logic             z, z2;
  logic [7:0]       match_count;
  logic [1:0]       match_count2;
  logic [LEN_W-1:0] busy_fill, busy_fill2;

  int tests_run = 0;
  int tests_failed = 0;

  seq_detector_param #(.PAT_W(PAT_W), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .en(en), .w(w),
    .z(z), .match_count(match_count), .busy_fill(busy_fill)
  );

  seq_detector_param #(.PAT_W(PAT_W), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .load(load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .en(en), .w(w),
    .z(z2), .match_count(match_count2), .busy_fill(busy_fill2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One clock with the given enable/data; outputs are sampled 1 time unit after the edge.
  task automatic cycle(input logic e, input logic b);
    en = e;
    w  = b;
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] l, input logic ov);
    load        = 1'b1;
    cfg_pattern = p;
    cfg_len     = l;
    cfg_overlap = ov;
    cycle(1'b1, 1'b1);
    load = 1'b0;
  endtask

  // 11-bit stream shared by the overlap and non-overlap runs, bit 0 sent first.
  logic [10:0] stream  = 11'b01010110111;
  logic [10:0] z_ov    = 11'b01010010000;
  logic [10:0] z_nov   = 11'b00010010000;
  logic [7:0]  a5_bits = 8'b10100101;

  initial begin
    rst_n = 1'b0; load = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    en = 1'b1; w = 1'b0;

    // Reset held for two cycles with w toggling.
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b0);
    check("rst_z", 32'(z), 32'd0);
    check("rst_cnt", 32'(match_count), 32'd0);
    check("rst_fill", 32'(busy_fill), 32'd0);
    rst_n = 1'b1;

    // Defaults: len 8, pattern 0, so eight zeros complete a match.
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b0);
      check($sformatf("dflt_z_%0d", i), 32'(z), (i == 7) ? 32'd1 : 32'd0);
    end
    check("dflt_cnt", 32'(match_count), 32'd1);
    check("dflt_fill", 32'(busy_fill), 32'd8);

    // Overlapping detection of 101.
    do_load(8'b101, 4'd3, 1'b1);
    check("ov_load_fill", 32'(busy_fill), 32'd0);
    check("ov_load_cnt", 32'(match_count), 32'd0);
    check("ov_load_z", 32'(z), 32'd0);
    for (int i = 0; i < 11; i++) begin
      cycle(1'b1, stream[i]);
      check($sformatf("ov_z_%0d", i), 32'(z), 32'(z_ov[i]));
    end
    check("ov_cnt", 32'(match_count), 32'd3);

    // Non-overlapping detection of 101.
    do_load(8'b101, 4'd3, 1'b0);
    for (int i = 0; i < 11; i++) begin
      cycle(1'b1, stream[i]);
      check($sformatf("nov_z_%0d", i), 32'(z), 32'(z_nov[i]));
      if (i == 4 || i == 7) check($sformatf("nov_fill_%0d", i), 32'(busy_fill), 32'd0);
    end
    check("nov_cnt", 32'(match_count), 32'd2);

    // Length 0 clamps to 8; pattern A5 sent with a 3-cycle enable gap.
    do_load(8'hA5, 4'd0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, a5_bits[7-i]);
      check($sformatf("gap_z_%0d", i), 32'(z), 32'd0);
    end
    for (int g = 0; g < 3; g++) begin
      cycle(1'b0, ~w);
      check($sformatf("gap_idle_z_%0d", g), 32'(z), 32'd0);
      check($sformatf("gap_idle_fill_%0d", g), 32'(busy_fill), 32'd4);
    end
    for (int i = 4; i < 8; i++) begin
      cycle(1'b1, a5_bits[7-i]);
      check($sformatf("gap_z_%0d", i), 32'(z), (i == 7) ? 32'd1 : 32'd0);
    end
    check("gap_cnt", 32'(match_count), 32'd1);
    check("gap_fill", 32'(busy_fill), 32'd8);
    cycle(1'b0, 1'b0);
    check("gap_pulse_end", 32'(z), 32'd0);

    // Load after two of three pattern bits discards the partial match.
    do_load(8'b101, 4'd3, 1'b1);
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b0);
    do_load(8'b101, 4'd3, 1'b1);
    check("reload_fill", 32'(busy_fill), 32'd0);
    cycle(1'b1, 1'b1);
    check("reload_z", 32'(z), 32'd0);
    check("reload_cnt", 32'(match_count), 32'd0);

    // Length 1, pattern 1: seven ones give seven matches; 2-bit counter saturates.
    do_load(8'b1, 4'd1, 1'b1);
    for (int i = 0; i < 7; i++) begin
      cycle(1'b1, 1'b1);
      check($sformatf("sat_z_%0d", i), 32'(z2), 32'd1);
      check($sformatf("sat_cnt_%0d", i), 32'(match_count2), (i < 3) ? 32'(i + 1) : 32'd3);
    end
    check("sat_wide_cnt", 32'(match_count), 32'd7);
    cycle(1'b1, 1'b0);
    check("len1_miss_z", 32'(z), 32'd0);

    // Reset mid-stream clears every output on the next edge.
    cycle(1'b1, 1'b1);
    check("pre_rst_z", 32'(z), 32'd1);
    rst_n = 1'b0;
    cycle(1'b1, 1'b1);
    check("mid_rst_z", 32'(z), 32'd0);
    check("mid_rst_cnt", 32'(match_count), 32'd0);
    check("mid_rst_fill", 32'(busy_fill), 32'd0);
    check("mid_rst_cnt2", 32'(match_count2), 32'd0);
    rst_n = 1'b1;

    // Defaults restored: len 8 again, so one zero is not a match.
    cycle(1'b1, 1'b0);
    check("post_rst_z", 32'(z), 32'd0);
    check("post_rst_fill", 32'(busy_fill), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
